// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response and fetch->decode bundle.
// master = fetch stage; slave = memory model plus decode stage.
interface if_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic        if_id_ready;
    logic [31:0] if_id_PC;
    logic [31:0] if_id_NPC;
    logic [31:0] if_id_IR;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_id_valid, if_id_PC, if_id_NPC, if_id_IR,
        input  if_id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_id_valid, if_id_PC, if_id_NPC, if_id_IR,
        output if_id_ready
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: fetch PC, credit-limited pipelined imem requests, epoch-tagged
// in-order response buffer. Ports: clk, rst (async low), ex redirect, bus.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_PC,
    if_stage_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic          epoch;

    logic [31:0]   tag_pc [DEPTH];
    logic          tag_ep [DEPTH];
    logic [PW-1:0] tag_wr, tag_rd;
    logic [CW-1:0] out_cnt;

    logic [31:0]   buf_pc [DEPTH];
    logic [31:0]   buf_ir [DEPTH];
    logic [PW-1:0] buf_wr, buf_rd;
    logic [CW-1:0] buf_cnt;

    logic          buf_nonempty;
    logic          if_valid;
    logic          pop;
    logic          req_ok;
    logic          accept;
    logic          rsp;
    logic          push_buf;
    logic [UW-1:0] used;
    logic [31:0]   head_pc;
    logic          unused_tgt_lsb;

    assign unused_tgt_lsb = ^ex_target_PC[1:0];

    assign buf_nonempty = (buf_cnt != '0);
    assign if_valid     = buf_nonempty & ~ex_take_branch;
    assign pop          = if_valid & bus.if_id_ready;

    // Credits count requests in flight plus buffered words; a same-cycle
    // pop frees one slot early so streaming keeps one request per cycle.
    assign used   = {1'b0, out_cnt} + {1'b0, buf_cnt} - UW'(pop);
    assign req_ok = ~ex_take_branch & (used < UW'(DEPTH));
    assign accept = req_ok & bus.imem_req_ready;
    assign rsp    = bus.imem_rsp_valid;

    // Wrong-epoch responses and responses racing a redirect are dropped.
    assign push_buf = rsp & (tag_ep[tag_rd] == epoch) & ~ex_take_branch;

    assign bus.imem_req_valid = rst & req_ok;
    assign bus.imem_req_addr  = fetch_pc;

    assign head_pc       = buf_nonempty ? buf_pc[buf_rd] : 32'h0;
    assign bus.if_id_valid = if_valid;
    assign bus.if_id_PC    = head_pc;
    assign bus.if_id_NPC   = head_pc + 32'd4;
    assign bus.if_id_IR    = if_valid ? buf_ir[buf_rd] : NOP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            out_cnt  <= '0;
            buf_wr   <= '0;
            buf_rd   <= '0;
            buf_cnt  <= '0;
        end else begin
            // Tag FIFO keeps draining across redirects.
            if (accept) tag_wr <= tag_wr + 1'b1;
            if (rsp)    tag_rd <= tag_rd + 1'b1;
            out_cnt <= out_cnt + CW'(accept) - CW'(rsp);
            if (ex_take_branch) begin
                fetch_pc <= {ex_target_PC[31:2], 2'b00};
                epoch    <= ~epoch;
                buf_wr   <= '0;
                buf_rd   <= '0;
                buf_cnt  <= '0;
            end else begin
                if (accept)   fetch_pc <= fetch_pc + 32'd4;
                if (push_buf) buf_wr   <= buf_wr + 1'b1;
                if (pop)      buf_rd   <= buf_rd + 1'b1;
                buf_cnt <= buf_cnt + CW'(push_buf) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc[tag_wr] <= fetch_pc;
            tag_ep[tag_wr] <= epoch;
        end
        if (push_buf) begin
            buf_pc[buf_wr] <= tag_pc[tag_rd];
            buf_ir[buf_wr] <= bus.imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rsp && buf_cnt == CW'(DEPTH)));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a fixed-latency
// in-order memory model and a reference fetch-PC model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        take_branch = 1'b0;
    logic [31:0] target_pc = 32'h0;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .ex_take_branch(take_branch),
        .ex_target_PC(target_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    mem_t        mem_q [$];
    logic [31:0] sb [$];
    logic [31:0] acc_log [$];
    logic [31:0] pop_log [$];
    logic [31:0] exp_fetch;
    logic        hold_pend;
    logic [31:0] hold_addr;

    int          s_cyc;
    logic        s_req_valid, s_if_valid, s_accept, s_pop;
    logic [31:0] s_addr, s_pc, s_npc, s_ir;

    function automatic logic [31:0] instr(input logic [31:0] a);
        return a ^ 32'h5EED_0003;
    endfunction

    task automatic idle_inputs();
        take_branch = 1'b0;
        target_pc = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        bus.if_id_ready = 1'b0;
    endtask

    task automatic clear_model();
        mem_q.delete();
        sb.delete();
        acc_log.delete();
        pop_log.delete();
        exp_fetch = 32'h0;
        hold_pend = 1'b0;
    endtask

    // One clock cycle: present memory response, sample at negedge,
    // update the models, then advance to just after the next posedge.
    task automatic tick();
        logic [31:0] e;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = instr(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        @(negedge clk);
        s_cyc = cyc;
        s_req_valid = bus.imem_req_valid;
        s_addr = bus.imem_req_addr;
        s_if_valid = bus.if_id_valid;
        s_pc = bus.if_id_PC;
        s_npc = bus.if_id_NPC;
        s_ir = bus.if_id_IR;
        s_accept = s_req_valid & bus.imem_req_ready;
        s_pop = s_if_valid & bus.if_id_ready;
        if (hold_pend && !take_branch) begin
            n_tests++;
            if (s_req_valid !== 1'b1 || s_addr !== hold_addr) begin
                n_fail++;
                $display("FAIL req_hold cyc %0d: valid=%b addr=%h want 1/%h",
                         cyc, s_req_valid, s_addr, hold_addr);
            end
        end
        if (take_branch) begin
            n_tests++;
            if (s_req_valid !== 1'b0 || s_if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_squash cyc %0d: req_valid=%b if_valid=%b want 0/0",
                         cyc, s_req_valid, s_if_valid);
            end
        end
        if (!s_if_valid) begin
            n_tests++;
            if (s_ir !== NOP) begin
                n_fail++;
                $display("FAIL nop_ir cyc %0d: got %h want %h", cyc, s_ir, NOP);
            end
        end
        if (s_pop) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_extra cyc %0d: got pc %h want no instruction",
                         cyc, s_pc);
            end else begin
                e = sb.pop_front();
                pop_log.push_back(s_pc);
                if (s_pc !== e || s_npc !== e + 32'd4 || s_ir !== instr(e)) begin
                    n_fail++;
                    $display("FAIL pop cyc %0d: got pc/npc/ir %h/%h/%h want %h/%h/%h",
                             cyc, s_pc, s_npc, s_ir, e, e + 32'd4, instr(e));
                end
            end
        end
        if (s_accept) begin
            n_tests++;
            if (s_addr !== exp_fetch) begin
                n_fail++;
                $display("FAIL req_addr cyc %0d: got %h want %h", cyc, s_addr, exp_fetch);
            end
            acc_log.push_back(s_addr);
            mem_q.push_back('{addr: s_addr, due: cyc + lat});
            sb.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (take_branch) begin
            sb.delete();
            exp_fetch = {target_pc[31:2], 2'b00};
        end
        hold_pend = s_req_valid & ~bus.imem_req_ready;
        hold_addr = s_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 1;
    endtask

    task automatic drain();
        int n;
        bus.imem_req_ready = 1'b0;
        bus.if_id_ready = 1'b1;
        take_branch = 1'b0;
        n = 0;
        while ((sb.size() > 0 || mem_q.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        n_tests++;
        if (sb.size() != 0 || mem_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
        tick();
        n_tests++;
        if (s_if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got if_valid=%b want 0", s_if_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_req: got %b/%h want 0/00000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        n_tests++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_PC !== 32'h0 ||
            bus.if_id_NPC !== 32'h4 || bus.if_id_IR !== NOP) begin
            n_fail++;
            $display("FAIL reset_ifid: got %b/%h/%h/%h want 0/0/4/%h", bus.if_id_valid,
                     bus.if_id_PC, bus.if_id_NPC, bus.if_id_IR, NOP);
        end
        rst = 1'b1;
        cyc = 1;
        #1;
        n_tests++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: got %b/%h want 1/00000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_stream();
        int first;
        int npop;
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_id_ready = 1'b1;
        first = -1;
        npop = 0;
        repeat (12) begin
            tick();
            if (s_pop) begin
                if (first < 0) first = s_cyc;
                npop++;
            end
        end
        n_tests++;
        if (first != 3 || npop != 10) begin
            n_fail++;
            $display("FAIL stream: got first=%0d pops=%0d want 3/10", first, npop);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int nacc;
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_id_ready = 1'b0;
        nacc = 0;
        repeat (10) begin
            tick();
            if (s_accept) nacc++;
            if (s_if_valid) begin
                n_tests++;
                if (s_pc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL bp_hold: got pc %h want 00000000", s_pc);
                end
            end
        end
        n_tests++;
        if (nacc != DEPTH || s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_credits: got %0d reqs valid=%b want %0d/0",
                     nacc, s_req_valid, DEPTH);
        end
        bus.if_id_ready = 1'b1;
        repeat (10) tick();
        drain();
    endtask

    task automatic test_req_stall();
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_id_ready = 1'b1;
        repeat (2) tick();
        bus.imem_req_ready = 1'b0;
        repeat (3) begin
            tick();
            n_tests++;
            if (s_req_valid !== 1'b1 || s_addr !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold: got %b/%h want 1/00000008", s_req_valid, s_addr);
            end
        end
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (s_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_next: got %h want 0000000c", s_addr);
        end
        drain();
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        lat = 3;
        bus.imem_req_ready = 1'b1;
        bus.if_id_ready = 1'b1;
        repeat (2) tick();
        take_branch = 1'b1;
        target_pc = 32'h100;
        tick();
        take_branch = 1'b0;
        tick();
        n_tests++;
        if (s_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_addr: got %h want 00000100", s_addr);
        end
        n = 0;
        while (pop_log.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104) begin
            n_fail++;
            $display("FAIL redir_pcs: got %0d pops first %h want 00000100,00000104",
                     pop_log.size(), pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
        drain();
    endtask

    task automatic test_redirect_collide();
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_id_ready = 1'b1;
        repeat (4) tick();
        pop_log.delete();
        take_branch = 1'b1;
        target_pc = 32'h203;
        tick();
        take_branch = 1'b0;
        tick();
        n_tests++;
        if (s_if_valid !== 1'b0 || s_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL collide_next: got valid=%b addr=%h want 0/00000200",
                     s_if_valid, s_addr);
        end
        tick();
        n_tests++;
        if (s_if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_empty: got valid=%b want 0", s_if_valid);
        end
        tick();
        n_tests++;
        if (!s_pop || s_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL collide_first: got pop=%b pc=%h want 1/00000200", s_pop, s_pc);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_id_ready = 1'b1;
        take_branch = 1'b1;
        target_pc = 32'hFFFF_FFFC;
        tick();
        take_branch = 1'b0;
        acc_log.delete();
        repeat (2) tick();
        n_tests++;
        if (acc_log.size() != 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: got %0d reqs first %h want fffffffc,00000000",
                     acc_log.size(), acc_log.size() > 0 ? acc_log[0] : 32'hx);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 2;
        repeat (300) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.if_id_ready = ($urandom_range(0, 3) != 0);
            take_branch = ($urandom_range(0, 24) == 0);
            target_pc = $urandom();
            tick();
        end
        drain();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the in-order RISC-V pipeline, at the opposite end of the redirect path driven by the execute stage. It holds the fetch PC, issues pipelined requests to instruction memory over a valid/ready handshake, and buffers in-order responses. It delivers {PC, NPC, IR} to decode under a valid/ready handshake. A taken branch/jump from execute redirects the PC, and every response still in flight for the squashed path is discarded using a one-bit epoch tag.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, credit limit: outstanding requests plus buffered instructions. Must be a power of 2, ≥2.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (state clears while rst=0).
- ex_take_branch  in  1  redirect request from execute (already gated by valid_inst).
- ex_target_PC  in  32  redirect target; bits [1:0] are forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response valid. Responses return in order, one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- if_id_valid  out  1  instruction available to decode.
- if_id_ready  in  1  decode consumes this cycle.
- if_id_PC  out  32  PC of the presented instruction.
- if_id_NPC  out  32  if_id_PC + 4.
- if_id_IR  out  32  instruction; 32'h0000_0013 (NOP) when if_id_valid=0.

## Operation
- State:
  - fetch_pc.
  - epoch bit.
  - Tag FIFO (DEPTH entries, {pc, epoch}, one per outstanding request).
  - Instruction buffer (DEPTH entries, {pc, ir}).
  - Outstanding count and buffer count (0..DEPTH).
- pop = if_id_valid & if_id_ready.
- Issue rule: imem_req_valid = ~ex_take_branch & (outstanding + buf_count − pop < DEPTH). imem_req_addr = fetch_pc.
- Request accepted (valid & ready):
  - Push {fetch_pc, epoch} to the tag FIFO.
  - fetch_pc += 4, wrapping modulo 2^32.
  - outstanding++.
- Response:
  - Pop the tag FIFO and decrement outstanding.
  - If the tag epoch equals the current epoch and no redirect occurs this cycle, push {tag.pc, imem_rsp_data} to the buffer.
  - Otherwise drop the response silently.
- Redirect (ex_take_branch=1):
  - fetch_pc ← {ex_target_PC[31:2], 2'b00}.
  - Epoch toggles.
  - Buffer is flushed (buf_count ← 0).
  - Outstanding count and tag FIFO are kept, so old-epoch responses are still drained.
- Redirect priority: a redirect overrides a same-cycle accept, response push and pop.
- The decode output is squashed combinationally: if_id_valid = (buf_count≠0) & ~ex_take_branch.
- Credits guarantee the buffer never overflows. A response arriving into a full buffer is a design error; flag it with an assertion.
- A request may be withdrawn or its address changed only in a redirect cycle. Otherwise imem_req_valid and imem_req_addr hold stable until accepted.
- Simultaneous accept, response and pop in one cycle update all counters consistently, with net counts applied.

## Timing
- Reset values:
  - imem_req_valid=0 while rst=0, imem_req_addr=RESET_PC.
  - if_id_valid=0, if_id_PC=0, if_id_NPC=4, if_id_IR=NOP.
  - epoch=0, all counts 0.
- First cycle after rst deasserts: imem_req_valid=1, addr=RESET_PC.
- Fetch latency: request accepted in cycle N, response in N+L, if_id_valid in N+L+1 (buffer registered).
- Throughput: 1 instruction/cycle sustained when L < DEPTH and ready is constant.
- Redirect sampled in cycle N: imem_req_addr = target in N+1. The first target-path instruction appears at decode no earlier than N+3 with L=1.
- Backpressure: if_id_ready=0 holds the presented instruction stable. Once credits are exhausted, imem_req_valid falls.
- Reset mid-operation drops all in-flight state immediately. Responses for pre-reset requests must not arrive after reset.

## Test plan
- Reset, then imem_req_ready=1, L=1, if_id_ready=1 → PCs 0,4,8,… one per cycle from cycle 3; NPC = PC+4.
- if_id_ready=0 for 10 cycles → exactly DEPTH requests issued, if_id_PC held at 0x0, then in-order resume with no loss or duplication.
- imem_req_ready low for 3 cycles on 0x8 → addr held at 0x8 and valid held high; the next address is 0xC only after acceptance.
- L=3, redirect to 0x100 with 2 requests in flight → both responses dropped; next delivered PCs 0x100, 0x104.
- Redirect to 0x203 in the same cycle a valid current-epoch response arrives and decode pops → response dropped, buffer empty, next addr 0x200.
- fetch_pc=0xFFFF_FFFC, two fetches → addresses 0xFFFF_FFFC then 0x0000_0000.
